// File: rtl/act_lut_arbiter_pkg.sv
// Shared constants, pipeline stage record and output saturation for the
// shared activation LUT arbiter.
package act_lut_arbiter_pkg;
  localparam int ACT_DATA_W   = 8;
  localparam int ACT_ADDR_W   = 4;
  localparam int ACT_FRAC_W   = 4;
  localparam int ACT_ID_MAX_W = 3;
  localparam int ACT_DIFF_W   = ACT_DATA_W + 1;
  localparam int ACT_PROD_W   = 13;
  localparam int ACT_SUM_W    = 10;

  typedef struct packed {
    logic                         valid;
    logic [ACT_ID_MAX_W-1:0]      id;
    logic signed [ACT_DATA_W-1:0] x;
  } act_stage_t;

  function automatic logic signed [ACT_DATA_W-1:0] act_sat(
    input logic signed [ACT_SUM_W-1:0] s
  );
    if (s > 10'sd127) return 8'sh7f;
    else if (s < -10'sd128) return 8'sh80;
    else return s[ACT_DATA_W-1:0];
  endfunction
endpackage

// File: rtl/act_lut.sv
// 16-entry activation table returning the entry at addr and its upper
// neighbour for interpolation.
module act_lut
  import act_lut_arbiter_pkg::*;
(
  input  logic [ACT_ADDR_W-1:0]        addr,
  output logic signed [ACT_DATA_W-1:0] base,
  output logic signed [ACT_DATA_W-1:0] nxt
);
  logic [ACT_ADDR_W-1:0] nxt_addr;

  function automatic logic signed [ACT_DATA_W-1:0] lut(input logic [ACT_ADDR_W-1:0] a);
    logic signed [ACT_DATA_W-1:0] v;
    v = '0;
    case (a)
      4'd0:  v = 8'sh00;
      4'd1:  v = 8'sh10;
      4'd2:  v = 8'sh20;
      4'd3:  v = 8'sh30;
      4'd4:  v = 8'sh40;
      4'd5:  v = 8'sh50;
      4'd6:  v = 8'sh60;
      4'd7:  v = 8'sh70;
      4'd8:  v = 8'sh80;
      4'd9:  v = 8'sh90;
      4'd10: v = 8'sha0;
      4'd11: v = 8'shb0;
      4'd12: v = 8'shc0;
      4'd13: v = 8'shd0;
      4'd14: v = 8'she0;
      4'd15: v = 8'shf0;
      default: v = '0;
    endcase
    return v;
  endfunction

  // Address 7 is the positive maximum and clamps; 15 wraps to 0 so the
  // segment just below zero interpolates towards lut[0].
  always_comb begin
    nxt_addr = addr + 4'd1;
    if (addr == 4'd7) nxt_addr = 4'd7;
  end

  assign base = lut(addr);
  assign nxt  = lut(nxt_addr);
endmodule

// File: rtl/act_lut_arbiter.sv
// Round-robin sharing of one activation table among N_REQ requesters with a
// three-stage accept / lookup+multiply / add+saturate pipeline.
module act_lut_arbiter
  import act_lut_arbiter_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int ID_W  = 2
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [N_REQ-1:0]             req_valid,
  input  logic [N_REQ*ACT_DATA_W-1:0]  req_x,
  output logic [N_REQ-1:0]             req_ready,
  output logic                         rsp_valid,
  input  logic                         rsp_ready,
  output logic [ID_W-1:0]              rsp_id,
  output logic signed [ACT_DATA_W-1:0] rsp_y,
  output logic                         busy
);
  // Handshake: a transfer happens on a rising edge where valid && ready.
  // Valid never waits on ready; ready here depends only on pointer, request
  // bits and whether the output register can advance.
  logic                         adv;
  logic                         accept;
  logic [N_REQ-1:0]             grant;
  logic [ID_W-1:0]              grant_id;
  logic                         grant_any;
  logic [ID_W-1:0]              ptr;

  act_stage_t                   s0;
  logic                         s1_valid;
  logic [ID_W-1:0]              s1_id;
  logic signed [ACT_DATA_W-1:0] s1_base;
  logic signed [ACT_PROD_W-1:0] s1_prod;

  logic [ACT_ADDR_W-1:0]        lut_addr;
  logic [ACT_FRAC_W-1:0]        frac;
  logic signed [ACT_DATA_W-1:0] lut_base;
  logic signed [ACT_DATA_W-1:0] lut_next;
  logic signed [ACT_DIFF_W-1:0] diff;
  logic signed [ACT_PROD_W-1:0] prod;
  logic signed [ACT_PROD_W-1:0] prod_sh;
  logic signed [ACT_SUM_W-1:0]  sum;
  logic                         s0_valid_n;
  logic                         s1_valid_n;
  logic                         rsp_valid_n;
  logic                         unused_bits;

  assign adv    = !rsp_valid || rsp_ready;
  assign accept = grant_any && adv;

  always_comb begin
    int idx;
    grant     = '0;
    grant_id  = '0;
    grant_any = 1'b0;
    idx       = 0;
    for (int k = 0; k < N_REQ; k++) begin
      idx = (int'(ptr) + k) % N_REQ;
      if (!grant_any && req_valid[idx]) begin
        grant_any   = 1'b1;
        grant[idx]  = 1'b1;
        grant_id    = ID_W'(idx);
      end
    end
  end

  assign req_ready = grant & {N_REQ{adv}};

  assign lut_addr = s0.x[ACT_DATA_W-1:ACT_FRAC_W];
  assign frac     = s0.x[ACT_FRAC_W-1:0];

  act_lut u_lut (
    .addr (lut_addr),
    .base (lut_base),
    .nxt  (lut_next)
  );

  assign diff    = $signed({lut_next[ACT_DATA_W-1], lut_next}) - $signed({lut_base[ACT_DATA_W-1], lut_base});
  assign prod    = $signed({{(ACT_PROD_W-ACT_DIFF_W){diff[ACT_DIFF_W-1]}}, diff})
                 * $signed({{(ACT_PROD_W-ACT_FRAC_W){1'b0}}, frac});
  // Floor division by 16; the quotient always fits in the 10-bit sum.
  assign prod_sh = s1_prod >>> ACT_FRAC_W;
  assign sum     = $signed({{(ACT_SUM_W-ACT_DATA_W){s1_base[ACT_DATA_W-1]}}, s1_base})
                 + $signed(prod_sh[ACT_SUM_W-1:0]);

  assign unused_bits = ^{s0.id, prod_sh[ACT_PROD_W-1:ACT_SUM_W]};

  assign s0_valid_n  = adv ? accept   : s0.valid;
  assign s1_valid_n  = adv ? s0.valid : s1_valid;
  assign rsp_valid_n = adv ? s1_valid : rsp_valid;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr       <= '0;
      s0        <= '0;
      s1_valid  <= 1'b0;
      s1_id     <= '0;
      s1_base   <= '0;
      s1_prod   <= '0;
      rsp_valid <= 1'b0;
      rsp_id    <= '0;
      rsp_y     <= '0;
      busy      <= 1'b0;
    end else begin
      busy <= s0_valid_n | s1_valid_n | rsp_valid_n;
      if (accept) ptr <= (int'(grant_id) == N_REQ - 1) ? '0 : grant_id + 1'b1;
      if (adv) begin
        s0.valid <= accept;
        if (accept) begin
          s0.id <= ACT_ID_MAX_W'(grant_id);
          s0.x  <= req_x[int'(grant_id)*ACT_DATA_W +: ACT_DATA_W];
        end
        s1_valid  <= s0.valid;
        s1_id     <= s0.id[ID_W-1:0];
        s1_base   <= lut_base;
        s1_prod   <= prod;
        rsp_valid <= s1_valid;
        if (s1_valid) begin
          rsp_id <= s1_id;
          rsp_y  <= act_sat(sum);
        end
      end
    end
  end
endmodule

// File: doc/act_lut_arbiter.md
# act_lut_arbiter

Round-robin arbiter and sequencer that shares one 16-entry activation lookup table (4-bit address, signed 8-bit entries, base/next outputs) among N requesters, such as the LSTM gate units. It accepts signed 8-bit pre-activation values, splits each into a table address and a 4-bit fraction, and reads base and next entries from the table. It linearly interpolates between them and returns the saturated 8-bit result tagged with the requester index. It sits between the gate datapaths and the shared activation table, replacing per-gate table copies.

## Interface
- `N_REQ`, default 4: number of requesters (2..8).
- `ID_W`, default 2: width of the requester index, equal to clog2(N_REQ).
- `clk`, in, 1: system clock, rising edge.
- `rst_n`, in, 1: reset, asynchronous and active-low.
- `req_valid`, in, N_REQ: per-requester request valid.
- `req_x`, in, N_REQ*8: per-requester signed input, requester i at bits [8i+7:8i].
- `req_ready`, out, N_REQ: one-hot grant. Request i is accepted when `req_valid[i] && req_ready[i]`.
- `rsp_valid`, out, 1: result valid.
- `rsp_ready`, in, 1: consumer accepts the result.
- `rsp_id`, out, ID_W: index of the requester this result belongs to.
- `rsp_y`, out, 8: signed interpolated result.
- `busy`, out, 1: high while any pipeline stage holds a valid entry.

## Operation
- Pipeline stages:
  - S0 accept: arbitrate, then register x and id.
  - S1: table lookup plus multiply, registered.
  - S2: add plus saturate into the output register.
- Advance condition: `adv = !rsp_valid || rsp_ready`. When adv is low, every stage holds and all `req_ready` bits are 0.
- Arbitration:
  - Round-robin pointer `ptr`; reset value 0.
  - Grant goes to the first i with `req_valid[i]`, searching from ptr upward and wrapping modulo N_REQ.
  - `req_ready` is combinational: the grant bit ANDed with adv. It never depends on a requester waiting.
  - After an accepted grant to i, `ptr` becomes (i+1) mod N_REQ. With no accept, ptr holds.
- Address split: `address = x[7:4]`, `frac = x[3:0]` (unsigned).
- Table behaviour:
  - The table returns `base = lut[address]`.
  - `next` is `lut[address+1]`, with two exceptions: address 7 returns `lut[7]` (no extrapolation past the positive maximum), and address 15 returns `lut[0]` (continuity across zero).
  - The arbiter uses these outputs unmodified.
- Arithmetic:
  - `diff = next - base`, 9-bit signed.
  - `prod = diff * frac`, 13-bit signed, with frac zero-extended.
  - `sum = base + (prod >>> 4)`, 10-bit signed, arithmetic shift (floor).
  - `rsp_y` is sum saturated to [-128, 127].
- Response:
  - `rsp_id` and `rsp_y` stay stable while `rsp_valid && !rsp_ready`.
  - A result must never be dropped or duplicated.
- Reset:
  - Asserting `rst_n` low at any time clears all stage valids, `ptr`, `rsp_valid` and `busy` immediately.
  - `rsp_id` and `rsp_y` clear to 0.
  - In-flight requests are discarded; requesters re-issue.

## Timing
- Latency: accept at rising edge t gives `rsp_valid` high after edge t+2, if not stalled.
- Throughput: one request per cycle when `rsp_ready` is held high.
- Simultaneous events:
  - In the same cycle `rsp_ready` is high, S2 can retire, S1 and S0 shift, and a new request is accepted. There is no bubble.
  - Multiple `req_valid` bits in one cycle: exactly one grant, and losers wait.
  - A requester holding `req_valid` is served within N_REQ accepts.
- Stall: while `rsp_valid && !rsp_ready`, the pipeline freezes and up to 3 entries are held. No `req_ready` is issued.
- `busy` is registered and is the OR of the stage valids.
- The table path is combinational inside S1. The multiplier output is registered at the S1/S2 boundary.

## Structure
- Shared package holds:
  - `ACT_DATA_W` = 8, `ACT_ADDR_W` = 4, `ACT_FRAC_W` = 4.
  - The saturate function.
  - A typedef for the {valid, id, x} stage record.
- One sub-module: `act_lut`, the existing 16-entry base/next table. It is instantiated once and driven from S1's address.
- The round-robin grant logic stays inline and is not a separate module.

## Test plan
The table in all scenarios holds the linear ramp: entry a = 16 × signed(a).
- Single request, x=0x25 from requester 2 -> `rsp_y`=37, `rsp_id`=2, `rsp_valid` after edge t+2.
- Boundary inputs in sequence:
  - x=0x7F -> 112 (address 7, next = base).
  - x=0xF8 -> -8 (address 15 wraps to `lut[0]`).
  - x=0x80 -> -128.
  - x=0x00 -> 0.
- All 4 requesters valid continuously from reset, `rsp_ready`=1 -> grant order 0,1,2,3,0,…; one result per cycle; ids match the order.
- `rsp_ready` held low for 5 cycles with 4 requests pending -> exactly 3 accepted, `req_ready`=0 during the stall, `rsp_y` stable. After release, results arrive in order with no loss.
- `rst_n` pulsed low mid-stream with 2 entries in flight -> `rsp_valid`=0 and `busy`=0 immediately. After reset, the first grant goes to the lowest valid index (ptr=0).
- Random stimulus against a reference model of the interpolation formula, with random `rsp_ready` -> every accepted request returns exactly once with the correct id and saturated value.
